// File: rtl/digit_scan_if.sv
// Bundle between the scan controller and whatever drives/observes it.
// master = value source and display sink, slave = the controller.
interface digit_scan_if;
  logic        en;
  logic [15:0] value;
  logic        value_we;
  logic        sel0;
  logic        sel1;
  logic [3:0]  nibble;
  logic        blank;
  logic        frame_done;
  logic [1:0]  dbg_state;

  // Inputs are level-sampled on every rising clk edge; there is no back-pressure.
  // value_we is a one-cycle write strobe with no ready: every high cycle is accepted.
  modport master (
    output en, value, value_we,
    input  sel0, sel1, nibble, blank, frame_done, dbg_state
  );
  modport slave (
    input  en, value, value_we,
    output sel0, sel1, nibble, blank, frame_done, dbg_state
  );
endinterface

// File: rtl/digit_scan_controller.sv
// 4-digit time-multiplexed display scanner.
// Includes blanking gaps, leading-zero suppression and frame-synchronous value updates.
module digit_scan_controller #(
  parameter int unsigned DIV         = 50000,
  parameter int unsigned DWELL       = 4,
  parameter int unsigned GAP         = 1,
  parameter bit          LZ_SUPPRESS = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  digit_scan_if.slave    bus
);

  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   pending_q, pending_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    nibble_q, nibble_d;
  logic          blank_q, blank_d;
  logic          frame_done_q, frame_done_d;
  logic          tick;
  logic          upper_zero;

  assign tick = (state_q != ST_IDLE) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    presc_d      = '0;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    pending_d    = bus.value_we ? bus.value : pending_q;

    if (!bus.en) begin
      state_d = ST_IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      if (state_q != ST_IDLE && !tick) begin
        presc_d = presc_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_SHOW;
          idx_d    = 2'd0;
          cnt_d    = '0;
          shadow_d = pending_q;
        end
        ST_SHOW: begin
          if (tick) begin
            if (cnt_q == DWELL_LAST) begin
              cnt_d = '0;
              if (GAP > 0) begin
                state_d = ST_GAP;
              end else begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                  frame_done_d = 1'b1;
                  shadow_d     = pending_q;
                end
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (cnt_q == GAP_LAST) begin
              cnt_d   = '0;
              state_d = ST_SHOW;
              idx_d   = idx_q + 2'd1;
              if (idx_q == 2'd3) begin
                frame_done_d = 1'b1;
                shadow_d     = pending_q;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Leading-zero test looks at the digit being entered and every digit above it.
  always_comb begin
    upper_zero = 1'b0;
    case (idx_d)
      2'd1:    upper_zero = (shadow_d[15:4]  == 12'h000);
      2'd2:    upper_zero = (shadow_d[15:8]  == 8'h00);
      2'd3:    upper_zero = (shadow_d[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
  end

  always_comb begin
    sel_d    = (state_d == ST_IDLE) ? 2'd0 : idx_d;
    nibble_d = (state_d == ST_SHOW) ? shadow_d[{idx_d, 2'b00} +: 4] : 4'h0;
    blank_d  = (state_d != ST_SHOW) || (LZ_SUPPRESS && upper_zero);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      presc_q      <= '0;
      pending_q    <= '0;
      shadow_q     <= '0;
      sel_q        <= 2'd0;
      nibble_q     <= 4'h0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      presc_q      <= presc_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      sel_q        <= sel_d;
      nibble_q     <= nibble_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sel0       = sel_q[0];
  assign bus.sel1       = sel_q[1];
  assign bus.nibble     = nibble_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = frame_done_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Bench for digit_scan_controller: three builds (default, no zero suppression, no gap)
// share one stimulus; a slot/frame arithmetic model is compared every cycle.
module tb_digit_scan_controller;

  localparam int DIV   = 2;
  localparam int DWELL = 2;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic        value_we;

  int n_cmp  = 0;
  int n_fail = 0;
  int kk     = 0;

  digit_scan_if bus0 ();
  digit_scan_if bus1 ();
  digit_scan_if bus2 ();

  assign bus0.en = en; assign bus0.value = value; assign bus0.value_we = value_we;
  assign bus1.en = en; assign bus1.value = value; assign bus1.value_we = value_we;
  assign bus2.en = en; assign bus2.value = value; assign bus2.value_we = value_we;

  digit_scan_controller #(.DIV(DIV), .DWELL(DWELL), .GAP(1), .LZ_SUPPRESS(1'b1)) dut_main (
    .clk(clk), .rst(rst), .bus(bus0));
  digit_scan_controller #(.DIV(DIV), .DWELL(DWELL), .GAP(1), .LZ_SUPPRESS(1'b0)) dut_nolz (
    .clk(clk), .rst(rst), .bus(bus1));
  digit_scan_controller #(.DIV(DIV), .DWELL(DWELL), .GAP(0), .LZ_SUPPRESS(1'b1)) dut_gap0 (
    .clk(clk), .rst(rst), .bus(bus2));

  // Actual outputs packed as {sel[1:0], nibble[3:0], blank, frame_done}
  logic [7:0] act [3];
  assign act[0] = {bus0.sel1, bus0.sel0, bus0.nibble, bus0.blank, bus0.frame_done};
  assign act[1] = {bus1.sel1, bus1.sel0, bus1.nibble, bus1.blank, bus1.frame_done};
  assign act[2] = {bus2.sel1, bus2.sel0, bus2.nibble, bus2.blank, bus2.frame_done};

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: position inside the running scan decides everything
  int          p_gap [3] = '{1, 1, 0};
  bit          p_lz  [3] = '{1'b1, 1'b0, 1'b1};
  bit          m_act [3];
  int          m_k   [3];
  logic [15:0] m_sh  [3];
  logic [15:0] m_pend;
  bit          m_valid = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
        int fr;
        fr = 4 * (DWELL + p_gap[d]) * DIV;
        if (rst) begin
          m_act[d] = 1'b0; m_k[d] = 0; m_sh[d] = 16'h0;
        end else if (!en) begin
          m_act[d] = 1'b0;
        end else if (!m_act[d]) begin
          m_act[d] = 1'b1; m_k[d] = 0; m_sh[d] = m_pend;
        end else begin
          m_k[d] = m_k[d] + 1;
          if (m_k[d] % fr == 0) m_sh[d] = m_pend;
        end
      end
      if (rst) begin
        m_pend  = 16'h0;
        m_valid = 1'b1;
      end else if (value_we) begin
        m_pend = value;
      end
      #1;
      if (m_valid) begin
        for (int d = 0; d < 3; d++) begin
          int slot, dig, pos;
          bit show;
          logic [7:0] exp_v;
          logic [15:0] upper;
          slot = (DWELL + p_gap[d]) * DIV;
          if (!m_act[d]) begin
            exp_v = 8'b00_0000_1_0;
          end else begin
            dig   = (m_k[d] / slot) % 4;
            pos   = m_k[d] % slot;
            show  = (pos < DWELL * DIV);
            upper = m_sh[d] >> (4 * dig);
            exp_v[7:6] = 2'(dig);
            exp_v[5:2] = show ? upper[3:0] : 4'h0;
            exp_v[1]   = !show || (p_lz[d] && dig > 0 && upper == 16'h0);
            exp_v[0]   = (m_k[d] > 0) && (m_k[d] % (4 * slot) == 0);
          end
          n_cmp++;
          if (act[d] !== exp_v) begin
            n_fail++;
            $display("FAIL model dut%0d t=%0t: got sel=%0d nib=%h blank=%b fd=%b, want sel=%0d nib=%h blank=%b fd=%b",
                     d, $time, act[d][7:6], act[d][5:2], act[d][1], act[d][0],
                     exp_v[7:6], exp_v[5:2], exp_v[1], exp_v[0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    kk++;
  endtask

  task automatic goto_k(input int t);
    while (kk < t) step();
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic write_value(input logic [15:0] v);
    value    = v;
    value_we = 1'b1;
    step();
    value_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; value = 16'h0; value_we = 1'b0;
    repeat (3) step();
    chk("reset_sel",    {bus0.sel1, bus0.sel0}, 0);
    chk("reset_blank",  bus0.blank, 1);
    chk("reset_nibble", bus0.nibble, 0);
    chk("reset_fd",     bus0.frame_done, 0);
    rst = 1'b0;
    repeat (3) step();
    chk("idle_blank", bus0.blank, 1);

    write_value(16'h1A2B);
    en = 1'b1; kk = -1;
    goto_k(0);  chk("k0_nib", bus0.nibble, 'hB); chk("k0_blank", bus0.blank, 0);
    goto_k(4);  chk("k4_gap_blank", bus0.blank, 1); chk("k4_gap_sel", {bus0.sel1, bus0.sel0}, 0);
    chk("k4_gap0_nib", bus2.nibble, 'h2); chk("k4_gap0_blank", bus2.blank, 0);
    goto_k(6);  chk("k6_sel", {bus0.sel1, bus0.sel0}, 1); chk("k6_nib", bus0.nibble, 'h2);
    goto_k(12); chk("k12_nib", bus0.nibble, 'hA);
    goto_k(18); chk("k18_sel", {bus0.sel1, bus0.sel0}, 3); chk("k18_nib", bus0.nibble, 'h1);
    goto_k(23); chk("k23_fd", bus0.frame_done, 0);
    goto_k(24); chk("k24_fd", bus0.frame_done, 1); chk("k24_nib", bus0.nibble, 'hB);
    goto_k(25); chk("k25_fd", bus0.frame_done, 0);

    goto_k(30); write_value(16'h0040);
    goto_k(36); chk("midframe_old_nib", bus0.nibble, 'hA);
    goto_k(48); chk("k48_nib", bus0.nibble, 0); chk("k48_blank", bus0.blank, 0);
    goto_k(54); chk("k54_nib", bus0.nibble, 'h4); chk("k54_blank", bus0.blank, 0);
    goto_k(60); chk("k60_lz_blank", bus0.blank, 1); chk("k60_nolz_blank", bus1.blank, 0);
    goto_k(66); chk("k66_lz_blank", bus0.blank, 1);

    goto_k(70); write_value(16'h0000);
    goto_k(72); chk("zero_d0_blank", bus0.blank, 0); chk("zero_d0_nib", bus0.nibble, 0);
    goto_k(78); chk("zero_d1_blank", bus0.blank, 1); chk("zero_d1_nolz", bus1.blank, 0);

    goto_k(95); write_value(16'h5555);
    chk("wrap_we_fd", bus0.frame_done, 1); chk("wrap_we_nib", bus0.nibble, 0);
    goto_k(102); chk("wrap_we_still_blank", bus0.blank, 1);
    goto_k(120); chk("k120_nib", bus0.nibble, 'h5); chk("k120_fd", bus0.frame_done, 1);

    goto_k(133); chk("k133_sel", {bus0.sel1, bus0.sel0}, 2);
    en = 1'b0; step();
    chk("disable_sel", {bus0.sel1, bus0.sel0}, 0); chk("disable_blank", bus0.blank, 1);
    repeat (3) step();
    en = 1'b1; kk = -1;
    goto_k(0); chk("reen_sel", {bus0.sel1, bus0.sel0}, 0); chk("reen_nib", bus0.nibble, 'h5);
    goto_k(4); chk("reen_gap_blank", bus0.blank, 1);
    rst = 1'b1; step();
    chk("midgap_rst_blank", bus0.blank, 1); chk("midgap_rst_nib", bus0.nibble, 0);
    chk("midgap_rst_sel", {bus0.sel1, bus0.sel0}, 0);
    rst = 1'b0; kk = -1;
    goto_k(0); chk("post_rst_nib", bus0.nibble, 0); chk("post_rst_blank", bus0.blank, 0);
    goto_k(30);
    en = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
